eth_tx_sched: RTL and testbench

//  Schedules and shares the single GMII transmit path and the shared CRC32 generator between
//  two frame sources: the ARP transmitter (requests/replies) and the UDP transmitter.
//  - Latches ARP work from the ARP receive side and accepts UDP send requests.
//  - Grants one source at a time and fires its start pulse.
//  - Muxes that source's GMII/CRC signals to the PHY side.
//  - Enforces the inter-frame gap and a hung-transmitter watchdog.

---
 rtl/eth_pkg.sv | 22 ++
 rtl/eth_tx_mux.sv | 43 ++++
 rtl/eth_tx_sched.sv | 186 ++++++++++++++++++
 tb/tb_eth_tx_sched.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
// Shared types and defaults for the Ethernet transmit scheduler.
// Owner encoding, scheduler states and timing defaults.
package eth_pkg;

  localparam int IFG_CYCLES_DEF     = 12;
  localparam int TIMEOUT_CYCLES_DEF = 4096;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_ARP  = 2'd1,
    OWN_UDP  = 2'd2
  } owner_t;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_GRANT_ARP = 3'd1,
    ST_GRANT_UDP = 3'd2,
    ST_BUSY      = 3'd3,
    ST_GAP       = 3'd4
  } state_t;

endpackage

// File: rtl/eth_tx_mux.sv
// Selects the owning source's GMII/CRC signals from the registered owner.
// Purely combinational (0 cycles); everything is driven to 0 when nobody owns the path.
module eth_tx_mux
  import eth_pkg::*;
(
  input  owner_t      owner,
  input  logic        arp_gmii_tx_en,
  input  logic [7:0]  arp_gmii_txd,
  input  logic        arp_crc_en,
  input  logic        arp_crc_clr,
  input  logic        udp_gmii_tx_en,
  input  logic [7:0]  udp_gmii_txd,
  input  logic        udp_crc_en,
  input  logic        udp_crc_clr,
  output logic        gmii_tx_en,
  output logic [7:0]  gmii_txd,
  output logic        crc_en,
  output logic        crc_clr
);

  always_comb begin
    gmii_tx_en = 1'b0;
    gmii_txd   = 8'h00;
    crc_en     = 1'b0;
    crc_clr    = 1'b0;
    unique case (owner)
      OWN_ARP: begin
        gmii_tx_en = arp_gmii_tx_en;
        gmii_txd   = arp_gmii_txd;
        crc_en     = arp_crc_en;
        crc_clr    = arp_crc_clr;
      end
      OWN_UDP: begin
        gmii_tx_en = udp_gmii_tx_en;
        gmii_txd   = udp_gmii_txd;
        crc_en     = udp_crc_en;
        crc_clr    = udp_crc_clr;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/eth_tx_sched.sv
// Arbitrates the GMII transmit path and shared CRC between the ARP and UDP transmitters.
// Start pulse two cycles after a request; inter-frame gap and hung-transmitter watchdog.
module eth_tx_sched
  import eth_pkg::*;
#(
  parameter int IFG_CYCLES     = IFG_CYCLES_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
)
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        arp_req,
  input  logic        arp_req_type,
  input  logic [47:0] arp_req_mac,
  input  logic [31:0] arp_req_ip,
  input  logic        udp_req,
  output logic        udp_gnt,
  output logic        arp_tx_en,
  output logic        arp_tx_type,
  output logic [47:0] arp_des_mac,
  output logic [31:0] arp_des_ip,
  input  logic        arp_tx_done,
  input  logic        arp_gmii_tx_en,
  input  logic [7:0]  arp_gmii_txd,
  input  logic        arp_crc_en,
  input  logic        arp_crc_clr,
  output logic        udp_tx_start_en,
  input  logic        udp_tx_done,
  input  logic        udp_gmii_tx_en,
  input  logic [7:0]  udp_gmii_txd,
  input  logic        udp_crc_en,
  input  logic        udp_crc_clr,
  output logic        gmii_tx_en,
  output logic [7:0]  gmii_txd,
  output logic        crc_en,
  output logic        crc_clr,
  output logic        busy,
  output logic        timeout_err
);

  localparam int WD_W  = $clog2(TIMEOUT_CYCLES);
  localparam int GAP_W = $clog2(IFG_CYCLES + 1);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(IFG_CYCLES - 1);

  state_t            state_q, state_d;
  owner_t            owner_q, owner_d;
  owner_t            last_gnt_q, last_gnt_d;
  logic              arp_pend_q, arp_pend_d;
  logic              udp_pend_q, udp_pend_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic              arp_type_q, arp_type_d;
  logic [47:0]       arp_mac_q, arp_mac_d;
  logic [31:0]       arp_ip_q, arp_ip_d;
  logic              buf_type_q, buf_type_d;
  logic [47:0]       buf_mac_q, buf_mac_d;
  logic [31:0]       buf_ip_q, buf_ip_d;

  logic owner_done;
  logic wd_fire;
  logic arp_owns;
  logic mux_crc_clr;

  assign owner_done = (owner_q == OWN_ARP && arp_tx_done) ||
                      (owner_q == OWN_UDP && udp_tx_done);
  // A done in the last watchdog cycle is a normal completion, not an error.
  assign wd_fire    = (state_q == ST_BUSY) && (wd_q == WD_LAST) && !owner_done;
  assign arp_owns   = (state_q == ST_GRANT_ARP) ||
                      (state_q == ST_BUSY && owner_q == OWN_ARP);

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_gnt_d = last_gnt_q;
    wd_d       = wd_q;
    gap_d      = gap_q;
    arp_pend_d = arp_pend_q | arp_req;
    udp_pend_d = udp_req & (state_q != ST_GRANT_UDP);
    buf_type_d = arp_req ? arp_req_type : buf_type_q;
    buf_mac_d  = arp_req ? arp_req_mac  : buf_mac_q;
    buf_ip_d   = arp_req ? arp_req_ip   : buf_ip_q;
    // The in-flight ARP frame keeps its parameters; later requests wait in the buffer.
    arp_type_d = arp_owns ? arp_type_q : buf_type_d;
    arp_mac_d  = arp_owns ? arp_mac_q  : buf_mac_d;
    arp_ip_d   = arp_owns ? arp_ip_q   : buf_ip_d;

    unique case (state_q)
      ST_IDLE: begin
        if (arp_pend_q && (!udp_pend_q || last_gnt_q == OWN_UDP)) begin
          state_d = ST_GRANT_ARP;
        end else if (udp_pend_q) begin
          state_d = ST_GRANT_UDP;
        end
      end
      ST_GRANT_ARP: begin
        arp_pend_d = arp_req;
        owner_d    = OWN_ARP;
        last_gnt_d = OWN_ARP;
        wd_d       = '0;
        state_d    = ST_BUSY;
      end
      ST_GRANT_UDP: begin
        owner_d    = OWN_UDP;
        last_gnt_d = OWN_UDP;
        wd_d       = '0;
        state_d    = ST_BUSY;
      end
      ST_BUSY: begin
        wd_d = wd_q + 1'b1;
        if (owner_done || wd_fire) begin
          owner_d = OWN_NONE;
          gap_d   = '0;
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      owner_q    <= OWN_NONE;
      last_gnt_q <= OWN_UDP;
      arp_pend_q <= 1'b0;
      udp_pend_q <= 1'b0;
      wd_q       <= '0;
      gap_q      <= '0;
      arp_type_q <= 1'b0;
      arp_mac_q  <= '0;
      arp_ip_q   <= '0;
      buf_type_q <= 1'b0;
      buf_mac_q  <= '0;
      buf_ip_q   <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_gnt_q <= last_gnt_d;
      arp_pend_q <= arp_pend_d;
      udp_pend_q <= udp_pend_d;
      wd_q       <= wd_d;
      gap_q      <= gap_d;
      arp_type_q <= arp_type_d;
      arp_mac_q  <= arp_mac_d;
      arp_ip_q   <= arp_ip_d;
      buf_type_q <= buf_type_d;
      buf_mac_q  <= buf_mac_d;
      buf_ip_q   <= buf_ip_d;
    end
  end

  eth_tx_mux u_mux (
    .owner          (owner_q),
    .arp_gmii_tx_en (arp_gmii_tx_en),
    .arp_gmii_txd   (arp_gmii_txd),
    .arp_crc_en     (arp_crc_en),
    .arp_crc_clr    (arp_crc_clr),
    .udp_gmii_tx_en (udp_gmii_tx_en),
    .udp_gmii_txd   (udp_gmii_txd),
    .udp_crc_en     (udp_crc_en),
    .udp_crc_clr    (udp_crc_clr),
    .gmii_tx_en     (gmii_tx_en),
    .gmii_txd       (gmii_txd),
    .crc_en         (crc_en),
    .crc_clr        (mux_crc_clr)
  );

  assign crc_clr         = mux_crc_clr | wd_fire;
  assign timeout_err     = wd_fire;
  assign arp_tx_en       = (state_q == ST_GRANT_ARP);
  assign udp_tx_start_en = (state_q == ST_GRANT_UDP);
  assign udp_gnt         = (state_q == ST_GRANT_UDP);
  assign busy            = (state_q != ST_IDLE);
  assign arp_tx_type     = arp_type_q;
  assign arp_des_mac     = arp_mac_q;
  assign arp_des_ip      = arp_ip_q;

endmodule

// File: tb/tb_eth_tx_sched.sv
// Bench for eth_tx_sched: timeline model of grants/gaps/watchdog checked every cycle,
// plus directed scenarios with hand-computed cycle offsets and captured values.
module tb_eth_tx_sched;

  localparam int IFG = 12;
  localparam int TMO = 4096;
  localparam logic [47:0] MAC_A = 48'h84_A9_38_BF_C9_A0;
  localparam logic [31:0] IP_A  = 32'hA9FE_3378;
  localparam logic [47:0] MAC_C = 48'h11_22_33_44_55_66;
  localparam logic [31:0] IP_C  = 32'h0A00_0001;

  logic clk, rst_n;
  logic arp_req, arp_req_type;
  logic [47:0] arp_req_mac;
  logic [31:0] arp_req_ip;
  logic udp_req, udp_gnt, arp_tx_en, arp_tx_type;
  logic [47:0] arp_des_mac;
  logic [31:0] arp_des_ip;
  logic arp_tx_done, arp_gmii_tx_en, arp_crc_en, arp_crc_clr;
  logic [7:0] arp_gmii_txd;
  logic udp_tx_start_en, udp_tx_done, udp_gmii_tx_en, udp_crc_en, udp_crc_clr;
  logic [7:0] udp_gmii_txd;
  logic gmii_tx_en, crc_en, crc_clr, busy, timeout_err;
  logic [7:0] gmii_txd;

  int n_tests, n_fail;
  bit noise_en, hold_udp_en;

  eth_tx_sched dut (
    .clk(clk), .rst_n(rst_n),
    .arp_req(arp_req), .arp_req_type(arp_req_type), .arp_req_mac(arp_req_mac),
    .arp_req_ip(arp_req_ip), .udp_req(udp_req), .udp_gnt(udp_gnt),
    .arp_tx_en(arp_tx_en), .arp_tx_type(arp_tx_type), .arp_des_mac(arp_des_mac),
    .arp_des_ip(arp_des_ip), .arp_tx_done(arp_tx_done), .arp_gmii_tx_en(arp_gmii_tx_en),
    .arp_gmii_txd(arp_gmii_txd), .arp_crc_en(arp_crc_en), .arp_crc_clr(arp_crc_clr),
    .udp_tx_start_en(udp_tx_start_en), .udp_tx_done(udp_tx_done),
    .udp_gmii_tx_en(udp_gmii_tx_en), .udp_gmii_txd(udp_gmii_txd), .udp_crc_en(udp_crc_en),
    .udp_crc_clr(udp_crc_clr), .gmii_tx_en(gmii_tx_en), .gmii_txd(gmii_txd),
    .crc_en(crc_en), .crc_clr(crc_clr), .busy(busy), .timeout_err(timeout_err)
  );

  initial begin
    clk = 1'b0;
    forever #4 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Random traffic on both sources' GMII/CRC lines so the mux is exercised every cycle.
  always @(posedge clk) begin
    #1;
    if (noise_en) begin
      arp_gmii_tx_en = 1'($urandom); arp_gmii_txd = 8'($urandom);
      arp_crc_en = 1'($urandom); arp_crc_clr = 1'($urandom);
      udp_gmii_tx_en = 1'($urandom); udp_gmii_txd = 8'($urandom);
      udp_crc_en = 1'($urandom); udp_crc_clr = 1'($urandom);
    end else begin
      arp_gmii_tx_en = 1'b0; arp_gmii_txd = 8'h00; arp_crc_en = 1'b0; arp_crc_clr = 1'b0;
      udp_gmii_tx_en = hold_udp_en; udp_gmii_txd = 8'h00; udp_crc_en = 1'b0; udp_crc_clr = 1'b0;
    end
  end

  // Timeline model: who owns the path since which cycle, and when the gap ends.
  int cyc, m_owner, m_start, m_idle_from, mp;
  bit m_arp_pend, m_udp_pend, m_last_udp, m_arp_owned;
  logic m_type, n_type;
  logic [47:0] m_mac, n_mac;
  logic [31:0] m_ip, n_ip;

  function automatic int phase_at(input int c);  // 0 idle, 1 start, 2 sending, 3 gap
    if (m_owner != 0) return (c == m_start) ? 1 : 2;
    return (c < m_idle_from) ? 3 : 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc = 0; m_owner = 0; m_start = 0; m_idle_from = 0;
      m_arp_pend = 0; m_udp_pend = 0; m_last_udp = 1;
      m_type = 0; m_mac = '0; m_ip = '0; n_type = 0; n_mac = '0; n_ip = '0;
    end else begin
      mp = phase_at(cyc);
      m_arp_owned = (mp == 1 || mp == 2) && m_owner == 1;
      if (mp == 2 && ((m_owner == 1 ? arp_tx_done : udp_tx_done) || cyc - m_start == TMO)) begin
        m_owner = 0;
        m_idle_from = cyc + IFG + 1;
      end
      if (mp == 0 && (m_arp_pend || m_udp_pend)) begin
        m_owner = (m_arp_pend && (!m_udp_pend || m_last_udp)) ? 1 : 2;
        m_last_udp = (m_owner == 2);
        m_start = cyc + 1;
      end
      if (mp == 1 && m_owner == 1) m_arp_pend = arp_req;
      else if (arp_req) m_arp_pend = 1;
      m_udp_pend = udp_req && !(mp == 1 && m_owner == 2);
      if (arp_req) begin
        n_type = arp_req_type; n_mac = arp_req_mac; n_ip = arp_req_ip;
      end
      if (!m_arp_owned) begin
        m_type = n_type; m_mac = n_mac; m_ip = n_ip;
      end
      cyc = cyc + 1;
    end
  end

  int cp;
  logic od, e_to, e_en, e_ce, e_cc;
  logic [7:0] e_txd;

  always @(negedge clk) begin
    if (rst_n) begin
      cp = phase_at(cyc);
      od = (m_owner == 1) ? arp_tx_done : (m_owner == 2) ? udp_tx_done : 1'b0;
      e_to = (cp == 2) && (cyc - m_start == TMO) && !od;
      e_en = 0; e_txd = 8'h00; e_ce = 0; e_cc = 0;
      if (cp == 2 && m_owner == 1) begin
        e_en = arp_gmii_tx_en; e_txd = arp_gmii_txd; e_ce = arp_crc_en; e_cc = arp_crc_clr;
      end else if (cp == 2 && m_owner == 2) begin
        e_en = udp_gmii_tx_en; e_txd = udp_gmii_txd; e_ce = udp_crc_en; e_cc = udp_crc_clr;
      end
      chk("busy", 64'(busy), 64'(cp != 0));
      chk("arp_tx_en", 64'(arp_tx_en), 64'(cp == 1 && m_owner == 1));
      chk("udp_tx_start_en", 64'(udp_tx_start_en), 64'(cp == 1 && m_owner == 2));
      chk("udp_gnt", 64'(udp_gnt), 64'(cp == 1 && m_owner == 2));
      chk("gmii_tx_en", 64'(gmii_tx_en), 64'(e_en));
      chk("gmii_txd", 64'(gmii_txd), 64'(e_txd));
      chk("crc_en", 64'(crc_en), 64'(e_ce));
      chk("crc_clr", 64'(crc_clr), 64'(e_cc | e_to));
      chk("timeout_err", 64'(timeout_err), 64'(e_to));
      chk("arp_tx_type", 64'(arp_tx_type), 64'(m_type));
      chk("arp_des_mac", 64'(arp_des_mac), 64'(m_mac));
      chk("arp_des_ip", 64'(arp_des_ip), 64'(m_ip));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_arp(input logic t, input logic [47:0] mac, input logic [31:0] ip);
    arp_req = 1'b1; arp_req_type = t; arp_req_mac = mac; arp_req_ip = ip;
    step();
    arp_req = 1'b0;
  endtask

  // which: 0 arp_tx_en, 1 udp_gnt, 2 timeout_err; returns at the negedge of the pulse cycle
  task automatic wait_pulse(input int which, input int limit, input string name, output int at);
    at = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if ((which == 0 && arp_tx_en) || (which == 1 && udp_gnt) || (which == 2 && timeout_err)) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      n_tests++; n_fail++;
      $display("FAIL %s: no pulse within %0d cycles", name, limit);
    end
  endtask

  task automatic wait_idle(input string name);
    bit seen;
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!busy) begin
        seen = 1;
        break;
      end
    end
    if (!seen) begin
      n_tests++; n_fail++;
      $display("FAIL %s: busy still 1 after 60 cycles", name);
    end
    step();
  endtask

  task automatic pulse_done(input bit is_udp);
    if (is_udp) udp_tx_done = 1'b1; else arp_tx_done = 1'b1;
    step();
    udp_tx_done = 1'b0; arp_tx_done = 1'b0;
  endtask

  int r, g, g2, d, t, gap_cycles, who;
  bit en_seen, busy_seen;

  initial begin
    n_tests = 0; n_fail = 0; noise_en = 0; hold_udp_en = 0;
    rst_n = 1'b0; arp_req = 0; arp_req_type = 0; arp_req_mac = '0; arp_req_ip = '0;
    udp_req = 0; arp_tx_done = 0; udp_tx_done = 0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_gmii_tx_en", 64'(gmii_tx_en), 64'(0));
    chk("rst_arp_des_mac", 64'(arp_des_mac), 64'(0));
    chk("rst_udp_gnt", 64'(udp_gnt), 64'(0));
    #1 rst_n = 1'b1;
    step();

    // 1: single ARP request, latency, captured values, gap length
    noise_en = 1;
    r = cyc;
    drive_arp(1'b1, MAC_A, IP_A);
    wait_pulse(0, 10, "t1_arp_tx_en", g);
    chk("t1_latency", 64'(g - r), 64'(2));
    chk("t1_type", 64'(arp_tx_type), 64'(1));
    chk("t1_mac", 64'(arp_des_mac), 64'(MAC_A));
    chk("t1_ip", 64'(arp_des_ip), 64'(IP_A));
    step();
    repeat (4) step();
    pulse_done(1'b1);  // non-owner done, must be ignored
    repeat (3) step();
    chk("t1_still_busy", 64'(busy), 64'(1));
    pulse_done(1'b0);
    gap_cycles = 0; en_seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!busy) break;
      gap_cycles++;
      en_seen |= gmii_tx_en;
    end
    chk("t1_gap_len", 64'(gap_cycles), 64'(IFG));
    chk("t1_gap_gmii", 64'(en_seen), 64'(0));
    step();

    // 2: simultaneous requests from reset, ARP first, UDP after done + gap
    rst_n = 1'b0; step(); #2 rst_n = 1'b1; step();
    udp_req = 1'b1;
    r = cyc;
    drive_arp(1'b0, MAC_C, IP_C);
    wait_pulse(0, 10, "t2_arp_tx_en", g);
    chk("t2_arp_first", 64'(g - r), 64'(2));
    step();
    repeat (4) step();
    d = cyc;
    pulse_done(1'b0);
    wait_pulse(1, 40, "t2_udp_gnt", g2);
    chk("t2_udp_after_gap", 64'(g2 - d), 64'(IFG + 2));
    chk("t2_udp_start", 64'(udp_tx_start_en), 64'(1));
    step();
    udp_req = 1'b0;
    @(negedge clk);
    chk("t2_gnt_width", 64'(udp_gnt), 64'(0));
    step();
    repeat (3) step();
    pulse_done(1'b1);
    wait_idle("t2_idle");

    // 3: UDP held, ARP re-requested: grants alternate A,U,A,U,A,U
    udp_req = 1'b1;
    drive_arp(1'b1, MAC_A, IP_A);
    for (int k = 0; k < 6; k++) begin
      who = -1;
      for (int i = 0; i < 60 && who < 0; i++) begin
        @(negedge clk);
        if (arp_tx_en) who = 0;
        else if (udp_tx_start_en) who = 1;
      end
      chk("t3_order", 64'(who), 64'(k % 2));
      step();
      if (who == 0 && k < 4) drive_arp(1'b1, MAC_A, IP_A);
      repeat (2) step();
      pulse_done(who == 1);
    end
    udp_req = 1'b0;
    wait_idle("t3_idle");

    // 4: ARP never finishes -> watchdog, then pending UDP served
    noise_en = 0;
    udp_req = 1'b1;
    drive_arp(1'b0, MAC_A, IP_A);
    wait_pulse(0, 10, "t4_arp_tx_en", g);
    step();
    wait_pulse(2, TMO + 20, "t4_timeout", t);
    chk("t4_timeout_at", 64'(t - g), 64'(TMO));
    chk("t4_crc_clr", 64'(crc_clr), 64'(1));
    step();
    wait_pulse(1, 40, "t4_udp_gnt", g2);
    chk("t4_udp_after", 64'(g2 - t), 64'(IFG + 2));
    step();
    udp_req = 1'b0;
    repeat (2) step();
    pulse_done(1'b1);
    wait_idle("t4_idle");

    // 5: new ARP request during an ARP frame is held for the next frame
    noise_en = 1;
    drive_arp(1'b1, MAC_A, IP_A);
    wait_pulse(0, 10, "t5_arp_tx_en", g);
    step();
    drive_arp(1'b0, MAC_C, IP_C);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t5_mac_held", 64'(arp_des_mac), 64'(MAC_A));
    end
    step();
    pulse_done(1'b0);
    wait_pulse(0, 40, "t5_second_arp", g2);
    chk("t5_next_mac", 64'(arp_des_mac), 64'(MAC_C));
    chk("t5_next_ip", 64'(arp_des_ip), 64'(IP_C));
    chk("t5_next_type", 64'(arp_tx_type), 64'(0));
    step();
    step();
    pulse_done(1'b0);
    wait_idle("t5_idle");

    // 6: reset in the middle of a UDP frame with ARP pending
    noise_en = 0; hold_udp_en = 1;
    udp_req = 1'b1;
    wait_pulse(1, 10, "t6_udp_gnt", g);
    step();
    udp_req = 1'b0;
    drive_arp(1'b1, MAC_C, IP_C);
    step();
    @(negedge clk);
    chk("t6_pre_gmii", 64'(gmii_tx_en), 64'(1));
    #1 rst_n = 1'b0;
    #1;
    chk("t6_async_gmii", 64'(gmii_tx_en), 64'(0));
    chk("t6_async_busy", 64'(busy), 64'(0));
    step();
    #2 rst_n = 1'b1;
    step();
    hold_udp_en = 0;
    busy_seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      busy_seen |= busy;
    end
    chk("t6_no_stale_arp", 64'(busy_seen), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
